bcd_display_mux: RTL

Two-digit multiplexed 7-segment display driver sitting directly downstream of the two-digit decade up/down counter. It consumes the counter's BCD digit outputs and terminal-count pulse, snapshots both digits once per refresh frame to avoid tearing, and time-multiplexes them onto a shared active-low segment bus with per-digit anode enables. A terminal-count event stretches into a visible decimal-point flash.

---
 rtl/bcd_display_mux.sv | 81 ++++++++
 1 files changed

// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed active-low 7-segment driver with per-frame digit snapshot and TC-stretched dp flash.
// Outputs registered one cycle behind internal state; no backpressure. Optional LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module bcd_display_mux #(
  parameter int REFRESH_DIV = 4,
  parameter int FLASH_LEN   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count_0,
  input  logic [3:0] count_1,
  input  logic       TC,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = $clog2(FLASH_LEN + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FL_LOAD  = FW'(FLASH_LEN);

  logic [PW-1:0] pre;
  logic          sel;
  logic [3:0]    sh0;
  logic [3:0]    sh1;
  logic [FW-1:0] fl;
  logic          pre_wrap;
  logic [6:0]    seg_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign pre_wrap = (pre == PRE_LAST);

  always_comb begin
    seg_nxt = decode(sel ? sh1 : sh0);
`ifdef LEADING_ZERO_BLANK_EN
    if (sel && (sh1 == 4'd0)) seg_nxt = 7'b1111111;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
      sel <= 1'b0;
      sh0 <= 4'd0;
      sh1 <= 4'd0;
      fl  <= '0;
      seg <= 7'b1111111;
      an  <= 2'b11;
      dp  <= 1'b1;
    end else begin
      pre <= pre_wrap ? '0 : pre + PW'(1);
      if (pre_wrap) sel <= ~sel;
      // Snapshot only at frame end so both digits always come from the same sample.
      if (pre_wrap && sel) begin
        sh0 <= count_0;
        sh1 <= count_1;
      end
      if (TC)             fl <= FL_LOAD;
      else if (fl != '0)  fl <= fl - FW'(1);
      an  <= sel ? 2'b01 : 2'b10;
      seg <= seg_nxt;
      dp  <= (fl == '0);
    end
  end

endmodule
